// File: rtl/vc_pkg.sv
// ---------------------------------------------------------------------------
// vc_pkg
// Shared types and helpers for the victim_cache block.
//   state_t    : controller states (S_FLUSH exists only with VC_FLUSH_EN)
//   vc_entry_t : layout of one buffered line for the default configuration
//   offW/tagW  : line-offset and tag widths derived from the parameters
// Optional feature macro: VC_FLUSH_EN
// ---------------------------------------------------------------------------
package vc_pkg;

  localparam int VC_ADDR_W     = 32;
  localparam int VC_LINE_BYTES = 32;
  localparam int VC_LINE_W     = VC_LINE_BYTES * 8;
  localparam int VC_ENTRIES    = 4;

  // Number of byte-offset bits inside one line
  function automatic int offW(input int lineBytes);
    return $clog2(lineBytes);
  endfunction

  // Tag width: everything above the line offset
  function automatic int tagW(input int addrW, input int lineBytes);
    return addrW - $clog2(lineBytes);
  endfunction

  localparam int VC_TAG_W = tagW(VC_ADDR_W, VC_LINE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RD_FWD,
    S_RD_WAIT,
    S_EVICT,
    S_INSTALL
`ifdef VC_FLUSH_EN
    , S_FLUSH
`endif
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [VC_TAG_W-1:0]  tag;
    logic [VC_LINE_W-1:0] data;
  } vc_entry_t;

endpackage

// File: rtl/vc_lookup.sv
// ---------------------------------------------------------------------------
// vc_lookup
// Combinational match over all victim-buffer entries.
//   valid_i   : per-entry valid bits
//   tags_i    : all entry tags, entry i at [i*TAG_W +: TAG_W]
//   tag_i     : tag being looked up
//   hit_o     : some valid entry holds tag_i
//   hitIdx_o  : lowest matching index
//   anyFree_o : at least one entry is invalid
//   freeIdx_o : lowest invalid index
// ---------------------------------------------------------------------------
module vc_lookup
  import vc_pkg::*;
#(
  parameter int ENTRIES = VC_ENTRIES,
  parameter int TAG_W   = tagW(VC_ADDR_W, VC_LINE_BYTES),
  parameter int IDX_W   = $clog2(VC_ENTRIES)
) (
  input  logic [ENTRIES-1:0]       valid_i,
  input  logic [ENTRIES*TAG_W-1:0] tags_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic                     hit_o,
  output logic [IDX_W-1:0]         hitIdx_o,
  output logic                     anyFree_o,
  output logic [IDX_W-1:0]         freeIdx_o
);

  // Scanning from the top down lets the lowest index overwrite the result,
  // so duplicate matches resolve to the lowest entry.
  always_comb begin
    hit_o     = 1'b0;
    hitIdx_o  = '0;
    anyFree_o = 1'b0;
    freeIdx_o = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_i[i] && (tags_i[i*TAG_W +: TAG_W] == tag_i)) begin
        hit_o    = 1'b1;
        hitIdx_o = IDX_W'(i);
      end
      if (!valid_i[i]) begin
        anyFree_o = 1'b1;
        freeIdx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/victim_cache.sv
// ---------------------------------------------------------------------------
// victim_cache
// Fully-associative victim buffer between the L1 controller and l2_cache.
// Absorbs L1 writebacks, serves read hits locally, forwards read misses and
// dirty evictions downstream. One request in flight at a time.
//   clk, rst_n        : clock, synchronous active-low reset
//   up_req_*          : L1 request (ready only while idle)
//   up_resp_*         : one-cycle read response pulse with line data
//   dn_req_*          : request to l2_cache (valid/ready handshake)
//   dn_resp_*         : l2_cache read data
//   flush_req/done    : whole-buffer writeback/invalidate (VC_FLUSH_EN only)
// Optional feature macro: VC_FLUSH_EN
// ---------------------------------------------------------------------------
module victim_cache
  import vc_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int L1_LINE_BYTES = 32,
  parameter int L1_LINE_W     = L1_LINE_BYTES * 8,
  parameter int ENTRIES       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_req_valid,
  output logic                 up_req_ready,
  input  logic                 up_req_rw,
  input  logic [ADDR_W-1:0]    up_req_addr,
  input  logic [L1_LINE_W-1:0] up_req_wline,
  output logic                 up_resp_valid,
  output logic [L1_LINE_W-1:0] up_resp_rline,
  output logic                 dn_req_valid,
  input  logic                 dn_req_ready,
  output logic                 dn_req_rw,
  output logic [ADDR_W-1:0]    dn_req_addr,
  output logic [L1_LINE_W-1:0] dn_req_wline,
  input  logic                 dn_resp_valid,
  input  logic [L1_LINE_W-1:0] dn_resp_rline
`ifdef VC_FLUSH_EN
  ,
  input  logic                 flush_req,
  output logic                 flush_done
`endif
);

  localparam int OFF   = offW(L1_LINE_BYTES);
  localparam int TAG_W = tagW(ADDR_W, L1_LINE_BYTES);
  localparam int IDX_W = $clog2(ENTRIES);

  state_t               state_q;
  logic [ENTRIES-1:0]   valid_q;
  logic [ENTRIES-1:0]   dirty_q;
  logic [TAG_W-1:0]     tag_q  [ENTRIES];
  logic [L1_LINE_W-1:0] data_q [ENTRIES];
  logic [IDX_W-1:0]     rr_q;
  logic                 reqRw_q;
  logic [ADDR_W-1:0]    reqAddr_q;
  logic [L1_LINE_W-1:0] reqWline_q;
  logic [IDX_W-1:0]     slot_q;
  logic                 useRr_q;
`ifdef VC_FLUSH_EN
  logic [IDX_W-1:0]     flushIdx_q;
  logic                 flushing_q;
  logic                 flushLast;
`endif

  logic [ENTRIES*TAG_W-1:0] tagsFlat;
  logic                     hit;
  logic [IDX_W-1:0]         hitIdx;
  logic                     anyFree;
  logic [IDX_W-1:0]         freeIdx;
  logic [IDX_W-1:0]         slot_d;
  logic [IDX_W-1:0]         rr_d;

  // Flatten tags for the lookup block
  always_comb begin
    tagsFlat = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      tagsFlat[i*TAG_W +: TAG_W] = tag_q[i];
    end
  end

  vc_lookup #(
    .ENTRIES (ENTRIES),
    .TAG_W   (TAG_W),
    .IDX_W   (IDX_W)
  ) u_lookup (
    .valid_i   (valid_q),
    .tags_i    (tagsFlat),
    .tag_i     (reqAddr_q[ADDR_W-1:OFF]),
    .hit_o     (hit),
    .hitIdx_o  (hitIdx),
    .anyFree_o (anyFree),
    .freeIdx_o (freeIdx)
  );

  // Write-miss slot: lowest free entry, else the round-robin entry.
  // rr is a power-of-two counter so the increment wraps by itself.
  assign slot_d = anyFree ? freeIdx : rr_q;
  assign rr_d   = rr_q + IDX_W'(1);

  assign up_req_ready = (state_q == S_IDLE);

`ifdef VC_FLUSH_EN
  assign flushLast = (flushIdx_q == IDX_W'(ENTRIES - 1));
`endif

  // Controller, entry storage and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      dirty_q       <= '0;
      rr_q          <= '0;
      up_resp_valid <= 1'b0;
      up_resp_rline <= '0;
      dn_req_valid  <= 1'b0;
      dn_req_rw     <= 1'b0;
      dn_req_addr   <= '0;
      dn_req_wline  <= '0;
`ifdef VC_FLUSH_EN
      flush_done    <= 1'b0;
      flushIdx_q    <= '0;
      flushing_q    <= 1'b0;
`endif
    end else begin
      up_resp_valid <= 1'b0;
`ifdef VC_FLUSH_EN
      flush_done    <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
`ifdef VC_FLUSH_EN
          if (flush_req) begin
            flushIdx_q <= '0;
            flushing_q <= 1'b1;
            state_q    <= S_FLUSH;
          end else
`endif
          if (up_req_valid) begin
            reqRw_q    <= up_req_rw;
            reqAddr_q  <= up_req_addr;
            reqWline_q <= up_req_wline;
`ifdef VC_FLUSH_EN
            flushing_q <= 1'b0;
`endif
            state_q    <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (!reqRw_q) begin
            if (hit) begin
              up_resp_valid <= 1'b1;
              up_resp_rline <= data_q[hitIdx];
              state_q       <= S_IDLE;
            end else begin
              dn_req_valid <= 1'b1;
              dn_req_rw    <= 1'b0;
              dn_req_addr  <= reqAddr_q;
              state_q      <= S_RD_FWD;
            end
          end else if (hit) begin
            data_q[hitIdx]  <= reqWline_q;
            dirty_q[hitIdx] <= 1'b1;
            state_q         <= S_IDLE;
          end else begin
            slot_q  <= slot_d;
            useRr_q <= !anyFree;
            if (valid_q[slot_d] && dirty_q[slot_d]) begin
              dn_req_valid <= 1'b1;
              dn_req_rw    <= 1'b1;
              dn_req_addr  <= {tag_q[slot_d], {OFF{1'b0}}};
              dn_req_wline <= data_q[slot_d];
              state_q      <= S_EVICT;
            end else begin
              state_q <= S_INSTALL;
            end
          end
        end

        S_RD_FWD: begin
          if (dn_req_ready) begin
            dn_req_valid <= 1'b0;
            state_q      <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (dn_resp_valid) begin
            up_resp_rline <= dn_resp_rline;
            up_resp_valid <= 1'b1;
            state_q       <= S_IDLE;
          end
        end

        S_EVICT: begin
          if (dn_req_ready) begin
            dn_req_valid <= 1'b0;
`ifdef VC_FLUSH_EN
            if (flushing_q) begin
              valid_q[flushIdx_q] <= 1'b0;
              dirty_q[flushIdx_q] <= 1'b0;
              if (flushLast) begin
                flush_done <= 1'b1;
                rr_q       <= '0;
                state_q    <= S_IDLE;
              end else begin
                flushIdx_q <= flushIdx_q + IDX_W'(1);
                state_q    <= S_FLUSH;
              end
            end else
`endif
            state_q <= S_INSTALL;
          end
        end

        S_INSTALL: begin
          tag_q[slot_q]   <= reqAddr_q[ADDR_W-1:OFF];
          data_q[slot_q]  <= reqWline_q;
          valid_q[slot_q] <= 1'b1;
          dirty_q[slot_q] <= 1'b1;
          if (useRr_q) begin
            rr_q <= rr_d;
          end
          state_q <= S_IDLE;
        end

`ifdef VC_FLUSH_EN
        // Dirty entries leave through the S_EVICT handshake; clean or
        // empty ones are simply dropped.
        S_FLUSH: begin
          if (valid_q[flushIdx_q] && dirty_q[flushIdx_q]) begin
            dn_req_valid <= 1'b1;
            dn_req_rw    <= 1'b1;
            dn_req_addr  <= {tag_q[flushIdx_q], {OFF{1'b0}}};
            dn_req_wline <= data_q[flushIdx_q];
            state_q      <= S_EVICT;
          end else begin
            valid_q[flushIdx_q] <= 1'b0;
            dirty_q[flushIdx_q] <= 1'b0;
            if (flushLast) begin
              flush_done <= 1'b1;
              rr_q       <= '0;
              state_q    <= S_IDLE;
            end else begin
              flushIdx_q <= flushIdx_q + IDX_W'(1);
            end
          end
        end
`endif

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_victim_cache.sv
// ---------------------------------------------------------------------------
// tb_victim_cache
// Self-checking bench for victim_cache: directed test-plan steps followed by
// random traffic, all compared against a line-level model of the buffer.
// Optional feature macro: VC_FLUSH_EN (adds the flush scenario)
// ---------------------------------------------------------------------------
module tb_victim_cache;

  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = 32;
  localparam int LINE_W     = 256;
  localparam int ENTRIES    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              up_req_valid;
  logic              up_req_ready;
  logic              up_req_rw;
  logic [31:0]       up_req_addr;
  logic [LINE_W-1:0] up_req_wline;
  logic              up_resp_valid;
  logic [LINE_W-1:0] up_resp_rline;
  logic              dn_req_valid;
  logic              dn_req_ready;
  logic              dn_req_rw;
  logic [31:0]       dn_req_addr;
  logic [LINE_W-1:0] dn_req_wline;
  logic              dn_resp_valid;
  logic [LINE_W-1:0] dn_resp_rline;
`ifdef VC_FLUSH_EN
  logic              flush_req;
  logic              flush_done;
`endif

  always #5 clk = ~clk;

  victim_cache #(
    .ADDR_W        (ADDR_W),
    .L1_LINE_BYTES (LINE_BYTES),
    .L1_LINE_W     (LINE_W),
    .ENTRIES       (ENTRIES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .up_req_valid  (up_req_valid),
    .up_req_ready  (up_req_ready),
    .up_req_rw     (up_req_rw),
    .up_req_addr   (up_req_addr),
    .up_req_wline  (up_req_wline),
    .up_resp_valid (up_resp_valid),
    .up_resp_rline (up_resp_rline),
    .dn_req_valid  (dn_req_valid),
    .dn_req_ready  (dn_req_ready),
    .dn_req_rw     (dn_req_rw),
    .dn_req_addr   (dn_req_addr),
    .dn_req_wline  (dn_req_wline),
    .dn_resp_valid (dn_resp_valid),
    .dn_resp_rline (dn_resp_rline)
`ifdef VC_FLUSH_EN
    ,
    .flush_req     (flush_req),
    .flush_done    (flush_done)
`endif
  );

  int testCount = 0;
  int failCount = 0;

  // Line-level model: which addresses are buffered, with what data
  bit                mValid [ENTRIES];
  bit                mDirty [ENTRIES];
  logic [31:0]       mAddr  [ENTRIES];
  logic [LINE_W-1:0] mData  [ENTRIES];
  int                mRr;

  // Expectations for the current transaction
  bit                expDn;
  logic              expDnRw;
  logic [31:0]       expDnAddr;
  logic [LINE_W-1:0] expDnWline;
  bit                expResp;
  bit                expHit;
  logic [LINE_W-1:0] expLine;

  // Observations of the current transaction
  int                obsDnCount;
  int                obsRespCount;
  int                obsRespCycle;
  logic [LINE_W-1:0] obsRespLine;
  bit                obsTimeout;
  logic              obsRespAfter;

  logic [LINE_W-1:0] l2Line;

  task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                             input logic [LINE_W-1:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [LINE_W-1:0] randLine();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int modelFind(input logic [31:0] a);
    for (int i = 0; i < ENTRIES; i++) if (mValid[i] && mAddr[i] == a) return i;
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i] = 0;
      mDirty[i] = 0;
    end
    mRr = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_up_ready", up_req_ready, 1);
    checkOutput("rst_dn_valid", dn_req_valid, 0);
    checkOutput("rst_up_resp_valid", up_resp_valid, 0);
    checkOutput("rst_up_resp_rline", up_resp_rline, 0);
    checkOutput("rst_dn_addr", dn_req_addr, 0);
    rst_n = 1'b1;
    modelReset();
  endtask

  // Issues one L1 request and plays the L2 side until the DUT is idle again
  task automatic applyStimulus(input logic rw, input logic [31:0] addr,
                               input logic [LINE_W-1:0] wline,
                               input int readyDelay, input int respDelay);
    int  cyc;
    int  stall;
    int  respWait;
    bit  dnActive;
    bit  dnIsRead;
    bit  done;
    obsDnCount   = 0;
    obsRespCount = 0;
    obsRespCycle = -1;
    obsRespLine  = '0;
    obsTimeout   = 0;
    checkOutput("ready_before_req", up_req_ready, 1);
    up_req_valid = 1'b1;
    up_req_rw    = rw;
    up_req_addr  = addr;
    up_req_wline = wline;
    @(posedge clk);
    #1;
    up_req_valid = 1'b0;
    cyc = 0; stall = 0; respWait = -1; dnActive = 0; dnIsRead = 0; done = 0;
    while (!done) begin
      if (up_resp_valid) begin
        obsRespCount++;
        obsRespCycle = cyc;
        obsRespLine  = up_resp_rline;
      end
      if (up_req_ready) begin
        done = 1;
      end else if (cyc >= 200) begin
        obsTimeout = 1;
        done = 1;
      end else begin
        dn_resp_valid = 1'b0;
        if (respWait == 0) begin
          dn_resp_valid = 1'b1;
          dn_resp_rline = l2Line;
          respWait = -1;
        end else if (respWait > 0) begin
          respWait--;
        end
        if (dn_req_valid) begin
          if (!dnActive) begin
            dnActive = 1;
            dnIsRead = !dn_req_rw;
            obsDnCount++;
            stall = 0;
          end
          if (expDn) begin
            checkOutput("dn_rw", dn_req_rw, expDnRw);
            checkOutput("dn_addr", dn_req_addr, expDnAddr);
            if (expDnRw) checkOutput("dn_wline", dn_req_wline, expDnWline);
          end
          if (stall > 0) checkOutput("up_ready_while_stalled", up_req_ready, 0);
          dn_req_ready = (stall >= readyDelay);
          stall++;
        end else begin
          if (dnActive && dnIsRead) respWait = respDelay;
          dnActive     = 0;
          dn_req_ready = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    dn_req_ready  = 1'b0;
    dn_resp_valid = 1'b0;
    @(posedge clk);
    #1;
    obsRespAfter = up_resp_valid;
  endtask

  // Derives expectations from the model, runs the request, compares, updates
  task automatic doTxn(input string name, input logic rw, input logic [31:0] addr,
                       input logic [LINE_W-1:0] wline, input int readyDelay,
                       input int respDelay);
    int idx;
    int slot;
    bit useRr;
    idx = modelFind(addr);
    expDn = 0; expDnRw = 0; expDnAddr = '0; expDnWline = '0;
    expResp = 0; expHit = 0; expLine = '0;
    slot = -1; useRr = 0;
    if (!rw) begin
      expResp = 1;
      if (idx >= 0) begin
        expHit  = 1;
        expLine = mData[idx];
      end else begin
        expDn     = 1;
        expDnAddr = addr;
        expLine   = l2Line;
      end
    end else if (idx < 0) begin
      for (int i = 0; i < ENTRIES; i++) if (!mValid[i] && slot < 0) slot = i;
      if (slot < 0) begin
        useRr = 1;
        slot  = mRr;
      end
      if (mValid[slot] && mDirty[slot]) begin
        expDn      = 1;
        expDnRw    = 1;
        expDnAddr  = mAddr[slot];
        expDnWline = mData[slot];
      end
    end
    applyStimulus(rw, addr, wline, readyDelay, respDelay);
    checkOutput({name, "_timeout"}, obsTimeout, 0);
    checkOutput({name, "_dn_count"}, obsDnCount, expDn);
    checkOutput({name, "_resp_count"}, obsRespCount, expResp);
    if (expResp) checkOutput({name, "_rline"}, obsRespLine, expLine);
    if (expHit) checkOutput({name, "_hit_latency"}, obsRespCycle, 1);
    checkOutput({name, "_resp_one_pulse"}, obsRespAfter, 0);
    if (rw) begin
      if (idx >= 0) begin
        mData[idx]  = wline;
        mDirty[idx] = 1;
      end else begin
        mValid[slot] = 1;
        mDirty[slot] = 1;
        mAddr[slot]  = addr;
        mData[slot]  = wline;
        if (useRr) mRr = (mRr + 1) % ENTRIES;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LINE_W-1:0] d1;
    bit                respSeen;
    int                waitCyc;
    up_req_valid  = 1'b0;
    up_req_rw     = 1'b0;
    up_req_addr   = '0;
    up_req_wline  = '0;
    dn_req_ready  = 1'b0;
    dn_resp_valid = 1'b0;
    dn_resp_rline = '0;
    l2Line        = '0;
`ifdef VC_FLUSH_EN
    flush_req     = 1'b0;
`endif
    modelReset();
    doReset();

    // Read miss on an empty buffer goes to L2 and is not allocated
    l2Line = {32{8'hA5}};
    doTxn("rd_miss_1000", 1'b0, 32'h0000_1000, '0, 0, 3);
    l2Line = randLine();
    doTxn("rd_miss_1000_again", 1'b0, 32'h0000_1000, '0, 1, 0);

    // Write then read the same line: served locally
    d1 = randLine();
    doTxn("wr_2000", 1'b1, 32'h0000_2000, d1, 0, 0);
    doTxn("rd_hit_2000", 1'b0, 32'h0000_2000, '0, 0, 0);
    doTxn("wr_hit_2000", 1'b1, 32'h0000_2000, randLine(), 0, 0);
    doTxn("rd_hit_2000_new", 1'b0, 32'h0000_2000, '0, 0, 0);

    // Fill, then force a round-robin eviction with L2 stalling 5 cycles
    doReset();
    for (int i = 1; i <= 4; i++) doTxn("fill", 1'b1, 32'(i) * 32'h100, randLine(), 0, 0);
    doTxn("evict_500", 1'b1, 32'h0000_0500, randLine(), 5, 0);
    doTxn("rd_hit_500", 1'b0, 32'h0000_0500, '0, 0, 0);
    l2Line = randLine();
    doTxn("rd_miss_100", 1'b0, 32'h0000_0100, '0, 0, 1);
    doTxn("evict_rr1", 1'b1, 32'h0000_0600, randLine(), 2, 0);

    // Reset while the downstream request is still being offered
    up_req_valid = 1'b1; up_req_rw = 1'b0; up_req_addr = 32'h0000_9000;
    @(posedge clk); #1; up_req_valid = 1'b0;
    waitCyc = 0;
    while (!dn_req_valid && waitCyc < 10) begin @(posedge clk); #1; waitCyc++; end
    checkOutput("rst_fwd_dn_seen", dn_req_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_fwd_dn_drop", dn_req_valid, 0);
    rst_n = 1'b1;
    modelReset();

    // Reset while waiting for L2 data; the late response must be ignored
    up_req_valid = 1'b1; up_req_rw = 1'b0; up_req_addr = 32'h0000_9000;
    @(posedge clk); #1; up_req_valid = 1'b0;
    waitCyc = 0;
    while (!dn_req_valid && waitCyc < 10) begin @(posedge clk); #1; waitCyc++; end
    checkOutput("rdwait_dn_seen", dn_req_valid, 1);
    dn_req_ready = 1'b1;
    @(posedge clk); #1;
    dn_req_ready = 1'b0;
    checkOutput("rdwait_busy", up_req_ready, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("rdwait_rst_dn_valid", dn_req_valid, 0);
    checkOutput("rdwait_rst_up_ready", up_req_ready, 1);
    rst_n = 1'b1;
    dn_resp_valid = 1'b1;
    dn_resp_rline = randLine();
    respSeen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      dn_resp_valid = 1'b0;
      if (up_resp_valid) respSeen = 1;
    end
    checkOutput("late_resp_ignored", respSeen, 0);
    modelReset();
    l2Line = randLine();
    doTxn("post_rst_miss_600", 1'b0, 32'h0000_0600, '0, 0, 0);

    // Random traffic over more lines than entries
    for (int n = 0; n < 60; n++) begin
      l2Line = randLine();
      doTxn("rand", 1'($urandom_range(0, 1)),
            32'h0000_4000 + 32'($urandom_range(0, 11)) * 32'h20,
            randLine(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

`ifdef VC_FLUSH_EN
    begin
      logic [31:0] expFlush[$];
      int          expWrites;
      int          flushWrites;
      int          flushDones;
      bit          fdone;
      doReset();
      for (int i = 0; i < 3; i++) doTxn("flush_fill", 1'b1, 32'h0000_7000 + 32'(i) * 32'h20, randLine(), 0, 0);
      expFlush.delete();
      for (int i = 0; i < ENTRIES; i++) if (mValid[i] && mDirty[i]) expFlush.push_back(mAddr[i]);
      expWrites = expFlush.size();
      flush_req = 1'b1;
      @(posedge clk); #1;
      flush_req = 1'b0;
      dn_req_ready = 1'b1;
      flushWrites = 0; flushDones = 0; fdone = 0;
      for (int c = 0; c < 100 && !fdone; c++) begin
        if (dn_req_valid) begin
          flushWrites++;
          checkOutput("flush_dn_rw", dn_req_rw, 1);
          if (expFlush.size() > 0) checkOutput("flush_dn_addr", dn_req_addr, expFlush.pop_front());
        end
        if (flush_done) flushDones++;
        if (up_req_ready) fdone = 1;
        else begin @(posedge clk); #1; end
      end
      dn_req_ready = 1'b0;
      checkOutput("flush_completed", fdone, 1);
      checkOutput("flush_writes", flushWrites, expWrites);
      checkOutput("flush_done_pulses", flushDones, 1);
      modelReset();
      l2Line = randLine();
      doTxn("post_flush_miss", 1'b0, 32'h0000_7000, '0, 0, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
